// File: rtl/hex_keypad_scanner_pkg.sv
//==============================================================================
// Module  : hex_keypad_scanner_pkg
// Brief   : Shared FSM/scan-result encodings and key-code map for the keypad scanner.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package hex_keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } scan_res_t;

  // Pmod KYPD legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
  function automatic logic [3:0] kp_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'h0;
      4'hD:    code = 4'hF;
      4'hE:    code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_col_scan.sv
//==============================================================================
// Module  : keypad_col_scan
// Brief   : Column drive, row synchronizer and per-scan classification of a 4x4 keypad.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module keypad_col_scan
  import hex_keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic       Clk_I,
  input  logic       Rst_N_I,
  input  logic [3:0] Row_I,
  output logic [3:0] Col_O,
  output logic       Scan_Done_O,
  output scan_res_t  Scan_Res_O,
  output logic [3:0] Scan_Code_O
);

  localparam int c_dw = $clog2(SCAN_DIV);
  localparam logic [c_dw-1:0] c_dwell_last = c_dw'(SCAN_DIV - 1);

  logic [c_dw-1:0] r_dwell;
  logic [1:0]      r_col_idx;
  logic [3:0]      r_row_meta;
  logic [3:0]      r_row_sync;
  logic [11:0]     r_snap;       // rows seen for columns 0..2, column c in [c*4 +: 4]
  logic            w_last;
  logic [15:0]     w_pressed;
  logic [4:0]      w_npress;
  logic [1:0]      w_hit_row;
  logic [1:0]      w_hit_col;

  assign w_last    = (r_dwell == c_dwell_last);
  assign Col_O     = ~(4'b0001 << r_col_idx);
  // Column 3 is classified straight from the synchronizer on its sampling cycle.
  assign w_pressed = ~{r_row_sync, r_snap};

  always_comb begin
    w_npress  = '0;
    w_hit_row = '0;
    w_hit_col = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_pressed[i]) begin
        w_npress  = w_npress + 5'd1;
        w_hit_col = 2'(i >> 2);
        w_hit_row = 2'(i & 3);
      end
    end
  end

  always_ff @(posedge Clk_I or negedge Rst_N_I) begin
    if (!Rst_N_I) begin
      r_row_meta  <= 4'hF;
      r_row_sync  <= 4'hF;
      r_dwell     <= '0;
      r_col_idx   <= '0;
      r_snap      <= '1;
      Scan_Done_O <= 1'b0;
      Scan_Res_O  <= RES_NONE;
      Scan_Code_O <= 4'h0;
    end else begin
      r_row_meta  <= Row_I;
      r_row_sync  <= r_row_meta;
      Scan_Done_O <= 1'b0;
      if (w_last) begin
        r_dwell   <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        case (r_col_idx)
          2'd0: r_snap[3:0]  <= r_row_sync;
          2'd1: r_snap[7:4]  <= r_row_sync;
          2'd2: r_snap[11:8] <= r_row_sync;
          default: begin
            Scan_Done_O <= 1'b1;
            Scan_Code_O <= kp_map(w_hit_row, w_hit_col);
            if (w_npress == 5'd0)      Scan_Res_O <= RES_NONE;
            else if (w_npress == 5'd1) Scan_Res_O <= RES_KEY;
            else                       Scan_Res_O <= RES_MULTI;
          end
        endcase
      end else begin
        r_dwell <= r_dwell + c_dw'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hex_keypad_scanner.sv
//==============================================================================
// Module  : hex_keypad_scanner
// Brief   : Debounced 4x4 hex keypad scanner feeding a 32-bit right-to-left entry register.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module hex_keypad_scanner
  import hex_keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        Clk_I,
  input  logic        Rst_N_I,
  input  logic [3:0]  Row_I,
  output logic [3:0]  Col_O,
  input  logic        Clr_I,
  output logic        KeyValid_O,
  output logic [3:0]  KeyCode_O,
  output logic [31:0] Data_O
);

  localparam int c_cw = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(DEBOUNCE_SCANS - 1);

  logic            w_scan_done;
  scan_res_t       w_scan_res;
  logic [3:0]      w_scan_code;

  kp_state_t       r_state, w_state_nxt;
  logic [c_cw-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]      r_cand, w_cand_nxt;
  logic            w_accept;
  logic            w_is_key;

  logic            r_key_valid;
  logic [3:0]      r_key_code;
  logic [31:0]     r_data;

  keypad_col_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_col_scan (
    .Clk_I       (Clk_I),
    .Rst_N_I     (Rst_N_I),
    .Row_I       (Row_I),
    .Col_O       (Col_O),
    .Scan_Done_O (w_scan_done),
    .Scan_Res_O  (w_scan_res),
    .Scan_Code_O (w_scan_code)
  );

  // MULTI deliberately falls into the "not a key" bucket alongside NONE.
  assign w_is_key = (w_scan_res == RES_KEY);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    if (w_scan_done) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_key) begin
            w_cand_nxt  = w_scan_code;
            w_cnt_nxt   = c_cw'(1);
            w_state_nxt = ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (w_is_key && (w_scan_code == r_cand)) begin
            if (r_cnt >= c_cnt_last) begin
              w_accept    = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_HELD;
            end else begin
              w_cnt_nxt = r_cnt + c_cw'(1);
            end
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (!w_is_key) begin
            w_cnt_nxt   = c_cw'(1);
            w_state_nxt = ST_RELEASE;
          end
        end
        default: begin
          if (w_is_key) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_HELD;
          end else if (r_cnt >= c_cnt_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + c_cw'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk_I or negedge Rst_N_I) begin
    if (!Rst_N_I) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cand      <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
      r_data      <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cand      <= w_cand_nxt;
      r_key_valid <= w_accept;
      if (w_accept) r_key_code <= r_cand;
      if (Clr_I)         r_data <= 32'h0;
      else if (w_accept) r_data <= {r_data[27:0], r_cand};
    end
  end

  assign KeyValid_O = r_key_valid;
  assign KeyCode_O  = r_key_code;
  assign Data_O     = r_data;

endmodule

`default_nettype wire

// File: tb/tb_hex_keypad_scanner.sv
//==============================================================================
// Module  : tb_hex_keypad_scanner
// Brief   : Self-checking bench for hex_keypad_scanner with a scan-level reference model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hex_keypad_scanner;

  localparam int SCAN_DIV = 8;
  localparam int DEB      = 2;
  localparam int SCAN_CYC = 4 * SCAN_DIV;
  localparam logic [3:0] KTAB [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                       4'h4, 4'h5, 4'h6, 4'hB,
                                       4'h7, 4'h8, 4'h9, 4'hC,
                                       4'h0, 4'hF, 4'hE, 4'hD};
  localparam logic [3:0] COLSEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic        Clk_I   = 1'b0;
  logic        Rst_N_I = 1'b1;
  logic        Clr_I   = 1'b0;
  logic [3:0]  Row_I;
  logic [3:0]  Col_O;
  logic        KeyValid_O;
  logic [3:0]  KeyCode_O;
  logic [31:0] Data_O;

  logic [15:0] keys = 16'h0;   // bit row*4+col set = key held down
  int n_chk  = 0;
  int n_pass = 0;
  int pulses = 0;
  int p0;

  always #5 Clk_I = ~Clk_I;

  always_comb begin
    for (int r = 0; r < 4; r++) Row_I[r] = ~|(keys[r*4 +: 4] & ~Col_O);
  end

  hex_keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .Clk_I      (Clk_I),
    .Rst_N_I    (Rst_N_I),
    .Row_I      (Row_I),
    .Col_O      (Col_O),
    .Clr_I      (Clr_I),
    .KeyValid_O (KeyValid_O),
    .KeyCode_O  (KeyCode_O),
    .Data_O     (Data_O)
  );

  // Reference model: one decision per completed scan, visible one clock after scan end.
  int          cyc      = 0;
  int          keyless  = 0;
  int          run_len  = 0;
  bit          armed    = 1'b1;
  bit          pend     = 1'b0;
  logic [3:0]  run_code = 4'h0;
  logic [3:0]  pend_code = 4'h0;
  logic        exp_valid = 1'b0;
  logic [3:0]  exp_code  = 4'h0;
  logic [31:0] exp_data  = 32'h0;

  always @(posedge Clk_I or negedge Rst_N_I) begin
    if (!Rst_N_I) begin
      cyc = 0; keyless = 0; run_len = 0; armed = 1'b1; pend = 1'b0;
      exp_valid = 1'b0; exp_code = 4'h0; exp_data = 32'h0;
    end else begin
      exp_valid = pend;
      if (pend) exp_code = pend_code;
      if (Clr_I)     exp_data = 32'h0;
      else if (pend) exp_data = {exp_data[27:0], pend_code};
      pend = 1'b0;
      cyc++;
      if (cyc % SCAN_CYC == 0) begin
        int n, idx;
        n = 0; idx = 0;
        for (int i = 0; i < 16; i++) if (keys[i]) begin n++; idx = i; end
        if (n == 1) begin
          if (armed) begin
            if (run_len > 0 && KTAB[idx] == run_code) run_len++;
            else begin run_code = KTAB[idx]; run_len = 1; end
            if (run_len >= DEB) begin
              pend = 1'b1; pend_code = run_code;
              armed = 1'b0; keyless = 0; run_len = 0;
            end
          end else begin
            keyless = 0;
          end
        end else begin
          run_len = 0;
          if (!armed) begin
            keyless++;
            if (keyless >= DEB) armed = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge Clk_I) begin
    logic [3:0] ec;
    ec = 4'b1111 ^ (4'b0001 << ((cyc / SCAN_DIV) % 4));
    chk("model_col", 32'(Col_O), 32'(ec));
    chk("model_valid", 32'(KeyValid_O), 32'(exp_valid));
    chk("model_code", 32'(KeyCode_O), 32'(exp_code));
    chk("model_data", Data_O, exp_data);
    if (KeyValid_O === 1'b1) pulses++;
  end

  function automatic logic [15:0] kb(input int r, input int c);
    return 16'(1) << (r * 4 + c);
  endfunction

  task automatic scans(input logic [15:0] k, input int n);
    keys = k;
    repeat (n * SCAN_CYC) @(posedge Clk_I);
    #2;
  endtask

  initial begin
    #1 Rst_N_I = 1'b0;
    repeat (3) @(posedge Clk_I);
    #2;
    chk("rst_col", 32'(Col_O), 32'h0000000E);
    chk("rst_data", Data_O, 32'h0);
    chk("rst_valid", 32'(KeyValid_O), 32'h0);
    chk("rst_code", 32'(KeyCode_O), 32'h0);
    Rst_N_I = 1'b1;

    for (int i = 0; i < 8; i++) begin
      repeat (SCAN_DIV) @(posedge Clk_I);
      #2;
      chk("col_walk", 32'(Col_O), 32'(COLSEQ[(i + 1) % 4]));
    end

    p0 = pulses;
    scans(kb(1, 2), 5);
    scans(16'h0, 2);
    chk("key6_pulses", 32'(pulses - p0), 32'd1);
    chk("key6_code", 32'(KeyCode_O), 32'h6);
    chk("key6_data", Data_O, 32'h00000006);

    p0 = pulses;
    for (int d = 1; d <= 9; d++) begin
      scans(kb((d - 1) / 3, (d - 1) % 3), 2);
      scans(16'h0, 2);
    end
    chk("seq_pulses", 32'(pulses - p0), 32'd9);
    chk("seq_data", Data_O, 32'h23456789);
    chk("seq_model", exp_data, 32'h23456789);

    p0 = pulses;
    scans(kb(1, 1), 1);
    scans(16'h0, 1);
    scans(kb(1, 1), 1);
    scans(16'h0, 2);
    chk("bounce_none", 32'(pulses - p0), 32'd0);
    scans(kb(1, 1), 2);
    scans(16'h0, 2);
    chk("bounce_pulses", 32'(pulses - p0), 32'd1);
    chk("bounce_code", 32'(KeyCode_O), 32'h5);
    chk("bounce_data", Data_O, 32'h34567895);

    p0 = pulses;
    scans(kb(0, 0) | kb(0, 3), 2);
    chk("multi_none", 32'(pulses - p0), 32'd0);
    scans(kb(0, 0), 2);
    scans(16'h0, 2);
    chk("multi_pulses", 32'(pulses - p0), 32'd1);
    chk("multi_code", 32'(KeyCode_O), 32'h1);
    chk("multi_data", Data_O, 32'h45678951);

    p0 = pulses;
    scans(kb(3, 1), 2);
    Clr_I = 1'b1;
    @(posedge Clk_I);
    #2;
    Clr_I = 1'b0;
    keys  = 16'h0;
    chk("clr_valid", 32'(KeyValid_O), 32'h1);
    chk("clr_code", 32'(KeyCode_O), 32'hF);
    chk("clr_data", Data_O, 32'h0);
    repeat (SCAN_CYC - 1) @(posedge Clk_I);
    #2;
    scans(16'h0, 1);
    chk("clr_pulses", 32'(pulses - p0), 32'd1);

    scans(kb(0, 1), 1);
    repeat (10) @(posedge Clk_I);
    #2;
    Rst_N_I = 1'b0;
    keys    = 16'h0;
    #1;
    chk("midrst_col", 32'(Col_O), 32'h0000000E);
    chk("midrst_valid", 32'(KeyValid_O), 32'h0);
    chk("midrst_code", 32'(KeyCode_O), 32'h0);
    repeat (2) @(posedge Clk_I);
    #2;
    Rst_N_I = 1'b1;
    p0 = pulses;
    scans(16'h0, 3);
    chk("midrst_pulses", 32'(pulses - p0), 32'd0);
    chk("midrst_data", Data_O, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
